tm1638_responder: RTL and testbench
===================================

Name: tm1638_responder

Overview:
- Target-side model of a TM1638 LED/key controller, clocked by the fabric `clk`. Sits on the far end of the 3-wire STB/CLK/DIO bus that the team's TM1638 initiator drives.
- Decodes commands from the initiator and holds the 16-byte display RAM plus the display-control state.
- Returns a 4-byte key-scan on read commands.
- Used as a loopback partner for bring-up and for system simulation without a physical display board.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on stb_n, sclk and dio_in (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the sclk frequency.
- reset_n  in  1  reset; synchronous, active-low.
- stb_n  in  1  bus strobe, active-low; a frame lasts while it is low.
- sclk  in  1  bus clock; idles high; data is sampled on its rising edge.
- dio_in  in  1  bus data from the initiator.
- dio_out  out  1  bus data to the initiator, valid only while dio_oe=1.
- dio_oe  out  1  output enable for dio_out.
- buttons  in  8  key states; 1 = pressed.
- seg_ram  out  128  display RAM; address a is held in [8a+7:8a]; even addresses are digits, odd addresses are LEDs.
- disp_on  out  1  display enable from the last display-control command.
- bright  out  3  brightness from the last display-control command.
- frame_wr  out  1  one-cycle pulse when a frame that wrote at least one RAM byte ends.
- key_rd  out  1  one-cycle pulse when a key-read command is decoded.

Behaviour:
- Reset: seg_ram=0, disp_on=0, bright=0, dio_oe=0, dio_out=0, frame_wr=0, key_rd=0, auto-increment mode, addr=0, idle. Reset aborts any frame in progress. After reset is released, the block stays idle until the next stb_n falling edge, even if stb_n is already low.
- Edge detection: each pin is synchronized, and an edge is the XOR of the last two synchronized samples. Internal action occurs SYNC_STAGES+1 clk cycles after the pin transition.
- States: IDLE, CMD, WDATA, RDATA, IGNORE.
- IDLE -> CMD on stb_n falling edge; clear the bit counter and the "wrote" flag.
- Bit capture in CMD/WDATA: on each sclk rising edge, shift dio_in in LSB first. The byte is complete after 8 bits.
- Command decode on byte completion in CMD, by bits [7:6]:
  - 01 (data command): set fixed = bit2.
    - If bit1=1: snapshot buttons, pulse key_rd, go to RDATA.
    - Else: go to IGNORE.
  - 10 (display control): disp_on=bit3, bright=bits[2:0]; go to IGNORE.
  - 11 (address set): addr=bits[3:0]; go to WDATA.
  - 00: go to IGNORE.
- WDATA: each completed byte is written to seg_ram[addr] and sets the "wrote" flag.
  - If fixed=0, addr increments modulo 16 (15 wraps to 0).
  - Writes are unbounded: the 17th byte lands on the starting address again.
- RDATA:
  - dio_oe=1 immediately on entry.
  - Key bytes 0..3 are built from the snapshot, all other bits 0:
    - byte0: bit0=btn7, bit4=btn3
    - byte1: bit0=btn6, bit4=btn2
    - byte2: bit0=btn5, bit4=btn1
    - byte3: bit0=btn4, bit4=btn0
  - On each sclk falling edge, dio_out takes the next bit, LSB first, bytes 0..3 in order; the first falling edge after entry presents byte0 bit0.
  - After 32 bits, dio_out holds the last bit; rising edges are ignored.
- IGNORE: all sclk edges are ignored until stb_n rises.
- stb_n rising edge, from any state:
  - go to IDLE, dio_oe=0, and discard any partial byte;
  - pulse frame_wr if the "wrote" flag is set.
  - The fixed/auto mode and addr persist across frames.
- sclk edges while stb_n is high are ignored.
- An sclk edge and an stb_n rising edge detected in the same cycle: stb_n wins and the bit is discarded.

Decomposition:
- Package tm1638_pkg:
  - command-class constants CMD_DATA=2'b01, CMD_DISP=2'b10, CMD_ADDR=2'b11;
  - bit-position constants (READ_BIT=1, FIXED_BIT=2, DISP_ON_BIT=3);
  - RAM_DEPTH=16, KEY_BYTES=4;
  - state enum.
- Sub-module tm1638_pin_sync: SYNC_STAGES synchronizer plus rise/fall pulse outputs for stb_n, sclk and dio_in.

Test Plan:
- Display control: frame 0x8F -> disp_on=1, bright=7, frame_wr stays 0. Then frame 0x80 -> disp_on=0, bright=0.
- Auto-increment write:
  - 0x40 frame, then a frame of 0xC0 + 16 bytes 0x00..0x0F -> seg_ram[a]=a, and frame_wr pulses once at the stb_n rise.
  - Same with a 17th byte 0xEE -> seg_ram[0]=0xEE.
- Fixed-address write: 0x44 frame, then frame 0xC5, 0xAA, 0xBB -> seg_ram[5]=0xBB; all other bytes unchanged.
- Key read: buttons=8'b1000_0001, frame 0x42 then 32 sclk cycles.
  - Required: initiator samples bytes 0x01, 0x00, 0x00, 0x10.
  - key_rd pulses once; dio_oe drops after the stb_n rise.
- Aborted frame: frame 0xC3 plus 5 bits, then stb_n high -> seg_ram unchanged, no frame_wr. The next frame 0xC3, 0x5A -> seg_ram[3]=0x5A.
- Reset mid-write: reset_n low during the 2nd data byte -> all outputs return to their reset values. A full write frame after release completes correctly.

Source files
------------

// File: rtl/tm1638_pkg.sv
// Shared constants, FSM state type and key-scan packing for the TM1638 responder.
package tm1638_pkg;

    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    localparam int unsigned READ_BIT    = 1;
    localparam int unsigned FIXED_BIT   = 2;
    localparam int unsigned DISP_ON_BIT = 3;

    localparam int unsigned RAM_DEPTH = 16;
    localparam int unsigned KEY_BYTES = 4;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWdata,
        StRdata,
        StIgnore
    } state_e;

    // Key byte k carries button 7-k in bit 0 and button 3-k in bit 4.
    function automatic logic [8*KEY_BYTES-1:0] key_scan(input logic [7:0] buttons);
        logic [8*KEY_BYTES-1:0] keys;
        keys = '0;
        for (int i = 0; i < KEY_BYTES; i++) begin
            keys[8*i]     = buttons[7-i];
            keys[8*i + 4] = buttons[3-i];
        end
        return keys;
    endfunction

endpackage

// File: rtl/tm1638_pin_sync.sv
// Multi-stage synchronizer for the bus pins with rise/fall pulses taken from the last two samples.
module tm1638_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIDTH       = 3
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    // No reset: the chain keeps tracking the pins through reset, so a strobe that is
    // already low when reset lifts never shows up as a falling edge.
    always_ff @(posedge clk) begin
        stage_q[0] <= pins;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
        end
        prev_q <= stage_q[SYNC_STAGES-1];
    end

    assign level = stage_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/tm1638_responder.sv
// Target-side TM1638 model: decodes initiator frames into display RAM / control state and
// shifts a 4-byte key scan back on read commands.
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   stb_n,
    input  logic                   sclk,
    input  logic                   dio_in,
    output logic                   dio_out,
    output logic                   dio_oe,
    input  logic [7:0]             buttons,
    output logic [8*RAM_DEPTH-1:0] seg_ram,
    output logic                   disp_on,
    output logic [2:0]             bright,
    output logic                   frame_wr,
    output logic                   key_rd
);

    logic [2:0] pin_level, pin_rise, pin_fall;

    tm1638_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .WIDTH      (3)
    ) u_pin_sync (
        .clk  (clk),
        .pins ({dio_in, sclk, stb_n}),
        .level(pin_level),
        .rise (pin_rise),
        .fall (pin_fall)
    );

    logic stb_fall, stb_rise, sclk_rise, sclk_fall, dio_bit;
    assign stb_fall  = pin_fall[0];
    assign stb_rise  = pin_rise[0];
    assign sclk_rise = pin_rise[1];
    assign sclk_fall = pin_fall[1];
    assign dio_bit   = pin_level[2];

    logic unused_pins;
    assign unused_pins = ^{pin_level[1:0], pin_rise[2], pin_fall[2]};

    state_e                 state_q, state_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d, new_byte;
    logic                   wrote_q, wrote_d;
    logic                   fixed_q, fixed_d;
    logic [3:0]             addr_q, addr_d;
    logic [8*RAM_DEPTH-1:0] seg_ram_q, seg_ram_d;
    logic                   disp_on_q, disp_on_d;
    logic [2:0]             bright_q, bright_d;
    logic [8*KEY_BYTES-1:0] keys_q, keys_d;
    logic                   dio_out_q, dio_out_d;
    logic                   dio_oe_q, dio_oe_d;
    logic                   frame_wr_q, frame_wr_d;
    logic                   key_rd_q, key_rd_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            wrote_q    <= 1'b0;
            fixed_q    <= 1'b0;
            addr_q     <= '0;
            seg_ram_q  <= '0;
            disp_on_q  <= 1'b0;
            bright_q   <= '0;
            keys_q     <= '0;
            dio_out_q  <= 1'b0;
            dio_oe_q   <= 1'b0;
            frame_wr_q <= 1'b0;
            key_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wrote_q    <= wrote_d;
            fixed_q    <= fixed_d;
            addr_q     <= addr_d;
            seg_ram_q  <= seg_ram_d;
            disp_on_q  <= disp_on_d;
            bright_q   <= bright_d;
            keys_q     <= keys_d;
            dio_out_q  <= dio_out_d;
            dio_oe_q   <= dio_oe_d;
            frame_wr_q <= frame_wr_d;
            key_rd_q   <= key_rd_d;
        end
    end

    // Bits arrive LSB first, so each new bit enters at the top and shifts down.
    assign new_byte = {dio_bit, shift_q[7:1]};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        wrote_d    = wrote_q;
        fixed_d    = fixed_q;
        addr_d     = addr_q;
        seg_ram_d  = seg_ram_q;
        disp_on_d  = disp_on_q;
        bright_d   = bright_q;
        keys_d     = keys_q;
        dio_out_d  = dio_out_q;
        dio_oe_d   = dio_oe_q;
        frame_wr_d = 1'b0;
        key_rd_d   = 1'b0;

        // Strobe release ends the frame from any state and beats a same-cycle sclk edge.
        if (stb_rise) begin
            state_d    = StIdle;
            dio_oe_d   = 1'b0;
            frame_wr_d = wrote_q;
            wrote_d    = 1'b0;
            bit_cnt_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (stb_fall) begin
                        state_d   = StCmd;
                        bit_cnt_d = '0;
                        wrote_d   = 1'b0;
                    end
                end
                StCmd: begin
                    if (sclk_rise) begin
                        shift_d   = new_byte;
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd7) begin
                            bit_cnt_d = '0;
                            state_d   = StIgnore;
                            case (new_byte[7:6])
                                CMD_DATA: begin
                                    fixed_d = new_byte[FIXED_BIT];
                                    if (new_byte[READ_BIT]) begin
                                        keys_d   = key_scan(buttons);
                                        key_rd_d = 1'b1;
                                        dio_oe_d = 1'b1;
                                        state_d  = StRdata;
                                    end
                                end
                                CMD_DISP: begin
                                    disp_on_d = new_byte[DISP_ON_BIT];
                                    bright_d  = new_byte[2:0];
                                end
                                CMD_ADDR: begin
                                    addr_d  = new_byte[3:0];
                                    state_d = StWdata;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                StWdata: begin
                    if (sclk_rise) begin
                        shift_d   = new_byte;
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd7) begin
                            bit_cnt_d                        = '0;
                            seg_ram_d[{addr_q, 3'b000} +: 8] = new_byte;
                            wrote_d                          = 1'b1;
                            if (!fixed_q) begin
                                addr_d = addr_q + 4'd1;
                            end
                        end
                    end
                end
                StRdata: begin
                    if (sclk_fall && (bit_cnt_q < 6'(8 * KEY_BYTES))) begin
                        dio_out_d = keys_q[bit_cnt_q[4:0]];
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign seg_ram  = seg_ram_q;
    assign disp_on  = disp_on_q;
    assign bright   = bright_q;
    assign dio_out  = dio_out_q;
    assign dio_oe   = dio_oe_q;
    assign frame_wr = frame_wr_q;
    assign key_rd   = key_rd_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// Self-checking bench: drives TM1638 initiator frames and compares against a byte-level model.
module tb_tm1638_responder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         stb_n;
    logic         sclk;
    logic         dio_in;
    logic         dio_out;
    logic         dio_oe;
    logic [7:0]   buttons;
    logic [127:0] seg_ram;
    logic         disp_on;
    logic [2:0]   bright;
    logic         frame_wr;
    logic         key_rd;

    tm1638_responder #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .stb_n   (stb_n),
        .sclk    (sclk),
        .dio_in  (dio_in),
        .dio_out (dio_out),
        .dio_oe  (dio_oe),
        .buttons (buttons),
        .seg_ram (seg_ram),
        .disp_on (disp_on),
        .bright  (bright),
        .frame_wr(frame_wr),
        .key_rd  (key_rd)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int frame_wr_cnt = 0;
    int key_rd_cnt = 0;

    always @(negedge clk) begin
        if (frame_wr) frame_wr_cnt++;
        if (key_rd) key_rd_cnt++;
    end

    // Reference model state, kept per RAM address rather than as a bit vector.
    logic [7:0] m_ram [16];
    logic       m_fixed;
    logic       m_disp;
    logic [2:0] m_bright;
    logic [7:0] tx [0:31];

    function automatic logic [127:0] m_ram_vec();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = m_ram[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        m_fixed  = 1'b0;
        m_disp   = 1'b0;
        m_bright = 3'd0;
    endtask

    // Applies a frame of n complete bytes (command first) to the model.
    task automatic model_frame(input int n, output bit exp_fw);
        logic [7:0] c;
        logic [3:0] a;
        exp_fw = 1'b0;
        if (n < 1) return;
        c = tx[0];
        case (c[7:6])
            2'b01: m_fixed = c[2];
            2'b10: begin
                m_disp   = c[3];
                m_bright = c[2:0];
            end
            2'b11: begin
                a = c[3:0];
                for (int i = 1; i < n; i++) begin
                    m_ram[a] = tx[i];
                    exp_fw   = 1'b1;
                    if (!m_fixed) a = a + 4'd1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic half_bit();
        repeat (8) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sclk   = 1'b0;
            dio_in = b[i];
            half_bit();
            sclk = 1'b1;
            half_bit();
        end
    endtask

    task automatic start_frame();
        stb_n = 1'b0;
        half_bit();
    endtask

    task automatic end_frame();
        stb_n = 1'b1;
        half_bit();
        half_bit();
    endtask

    // Drives tx[0..n-1] plus an optional partial byte, updates the model, reports pulses.
    task automatic run_frame(input int n, input int extra_bits, input logic [7:0] extra,
                             output int got_fw, output bit exp_fw);
        int fw0;
        fw0 = frame_wr_cnt;
        start_frame();
        for (int i = 0; i < n; i++) send_bits(tx[i], 8);
        if (extra_bits > 0) send_bits(extra, extra_bits);
        end_frame();
        got_fw = frame_wr_cnt - fw0;
        model_frame(n, exp_fw);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        stb_n   = 1'b1;
        sclk    = 1'b1;
        dio_in  = 1'b0;
        buttons = 8'h00;
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        model_reset();
        checks++; if (seg_ram !== 128'h0) begin errors++; $display("FAIL reset_seg_ram: got %h want 0", seg_ram); end
        checks++; if (disp_on !== 1'b0) begin errors++; $display("FAIL reset_disp_on: got %b want 0", disp_on); end
        checks++; if (bright !== 3'd0) begin errors++; $display("FAIL reset_bright: got %0d want 0", bright); end
        checks++; if (dio_oe !== 1'b0) begin errors++; $display("FAIL reset_dio_oe: got %b want 0", dio_oe); end
        checks++; if (dio_out !== 1'b0) begin errors++; $display("FAIL reset_dio_out: got %b want 0", dio_out); end
        checks++; if (frame_wr_cnt !== 0) begin errors++; $display("FAIL reset_frame_wr: got %0d pulses want 0", frame_wr_cnt); end
        checks++; if (key_rd_cnt !== 0) begin errors++; $display("FAIL reset_key_rd: got %0d pulses want 0", key_rd_cnt); end
    endtask

    task automatic test_display();
        int got_fw;
        bit exp_fw;
        for (int it = 0; it < 8; it++) begin
            if (it == 0) tx[0] = 8'h8F;
            else if (it == 1) tx[0] = 8'h80;
            else tx[0] = {2'b10, 6'($urandom)};
            run_frame(1, 0, 8'h00, got_fw, exp_fw);
            checks++; if (disp_on !== m_disp) begin errors++; $display("FAIL disp_on cmd %h: got %b want %b", tx[0], disp_on, m_disp); end
            checks++; if (bright !== m_bright) begin errors++; $display("FAIL bright cmd %h: got %0d want %0d", tx[0], bright, m_bright); end
            checks++; if (got_fw !== 0) begin errors++; $display("FAIL disp_frame_wr cmd %h: got %0d pulses want 0", tx[0], got_fw); end
        end
        checks++; if (seg_ram !== m_ram_vec()) begin errors++; $display("FAIL disp_seg_ram: got %h want %h", seg_ram, m_ram_vec()); end
    endtask

    task automatic test_auto_write();
        int got_fw;
        bit exp_fw;
        tx[0] = 8'h40;
        run_frame(1, 0, 8'h00, got_fw, exp_fw);
        tx[0] = 8'hC0;
        for (int i = 0; i < 16; i++) tx[i+1] = 8'(i);
        run_frame(17, 0, 8'h00, got_fw, exp_fw);
        checks++; if (seg_ram !== m_ram_vec()) begin errors++; $display("FAIL auto16_seg_ram: got %h want %h", seg_ram, m_ram_vec()); end
        checks++; if (seg_ram[127:120] !== 8'h0F) begin errors++; $display("FAIL auto16_addr15: got %h want 0f", seg_ram[127:120]); end
        checks++; if (got_fw !== 1) begin errors++; $display("FAIL auto16_frame_wr: got %0d pulses want 1", got_fw); end
        tx[17] = 8'hEE;
        run_frame(18, 0, 8'h00, got_fw, exp_fw);
        checks++; if (seg_ram !== m_ram_vec()) begin errors++; $display("FAIL auto17_seg_ram: got %h want %h", seg_ram, m_ram_vec()); end
        checks++; if (seg_ram[7:0] !== 8'hEE) begin errors++; $display("FAIL auto17_wrap: got %h want ee", seg_ram[7:0]); end
        checks++; if (got_fw !== 1) begin errors++; $display("FAIL auto17_frame_wr: got %0d pulses want 1", got_fw); end
    endtask

    task automatic test_fixed_write();
        int got_fw;
        bit exp_fw;
        tx[0] = 8'h44;
        run_frame(1, 0, 8'h00, got_fw, exp_fw);
        tx[0] = 8'hC5;
        tx[1] = 8'hAA;
        tx[2] = 8'hBB;
        run_frame(3, 0, 8'h00, got_fw, exp_fw);
        checks++; if (seg_ram !== m_ram_vec()) begin errors++; $display("FAIL fixed_seg_ram: got %h want %h", seg_ram, m_ram_vec()); end
        checks++; if (seg_ram[47:40] !== 8'hBB) begin errors++; $display("FAIL fixed_addr5: got %h want bb", seg_ram[47:40]); end
        checks++; if (seg_ram[55:48] !== 8'h06) begin errors++; $display("FAIL fixed_addr6: got %h want 06", seg_ram[55:48]); end
        checks++; if (got_fw !== 1) begin errors++; $display("FAIL fixed_frame_wr: got %0d pulses want 1", got_fw); end
    endtask

    task automatic test_key_read();
        logic [7:0] cmd, got, want;
        int kr0, fw0, b;
        for (int it = 0; it < 5; it++) begin
            if (it == 0) begin
                buttons = 8'b1000_0001;
                cmd     = 8'h42;
            end else begin
                buttons = 8'($urandom);
                cmd     = 8'h42 | 8'($urandom & 4);
            end
            b   = int'(buttons);
            kr0 = key_rd_cnt;
            fw0 = frame_wr_cnt;
            start_frame();
            send_bits(cmd, 8);
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < 8; i++) begin
                    sclk = 1'b0;
                    half_bit();
                    got[i] = dio_out;
                    sclk = 1'b1;
                    half_bit();
                end
                want = 8'(((b >> (7 - k)) & 1) + (((b >> (3 - k)) & 1) * 16));
                checks++; if (got !== want) begin errors++; $display("FAIL key_byte%0d btn %h: got %h want %h", k, buttons, got, want); end
            end
            checks++; if (dio_oe !== 1'b1) begin errors++; $display("FAIL key_oe_during: got %b want 1", dio_oe); end
            end_frame();
            m_fixed = cmd[2];
            checks++; if (dio_oe !== 1'b0) begin errors++; $display("FAIL key_oe_after: got %b want 0", dio_oe); end
            checks++; if (key_rd_cnt - kr0 !== 1) begin errors++; $display("FAIL key_rd_pulses: got %0d want 1", key_rd_cnt - kr0); end
            checks++; if (frame_wr_cnt - fw0 !== 0) begin errors++; $display("FAIL key_frame_wr: got %0d want 0", frame_wr_cnt - fw0); end
        end
    endtask

    task automatic test_abort();
        int got_fw;
        bit exp_fw;
        tx[0] = 8'h40;
        run_frame(1, 0, 8'h00, got_fw, exp_fw);
        tx[0] = 8'hC3;
        run_frame(1, 5, 8'h1F, got_fw, exp_fw);
        checks++; if (seg_ram !== m_ram_vec()) begin errors++; $display("FAIL abort_seg_ram: got %h want %h", seg_ram, m_ram_vec()); end
        checks++; if (got_fw !== 0) begin errors++; $display("FAIL abort_frame_wr: got %0d pulses want 0", got_fw); end
        // sclk activity with the strobe high must not disturb anything.
        send_bits(8'hFF, 8);
        checks++; if (seg_ram !== m_ram_vec()) begin errors++; $display("FAIL idle_sclk_seg_ram: got %h want %h", seg_ram, m_ram_vec()); end
        tx[0] = 8'hC3;
        tx[1] = 8'h5A;
        run_frame(2, 0, 8'h00, got_fw, exp_fw);
        checks++; if (seg_ram[31:24] !== 8'h5A) begin errors++; $display("FAIL abort_next_addr3: got %h want 5a", seg_ram[31:24]); end
        checks++; if (seg_ram !== m_ram_vec()) begin errors++; $display("FAIL abort_next_seg_ram: got %h want %h", seg_ram, m_ram_vec()); end
    endtask

    task automatic test_random_writes();
        int got_fw, n;
        bit exp_fw;
        for (int it = 0; it < 10; it++) begin
            tx[0] = 8'h40 | 8'($urandom & 4);
            run_frame(1, 0, 8'h00, got_fw, exp_fw);
            tx[0] = 8'hC0 | 8'($urandom_range(0, 15));
            n     = $urandom_range(0, 20);
            for (int i = 1; i <= n; i++) tx[i] = 8'($urandom);
            run_frame(n + 1, 0, 8'h00, got_fw, exp_fw);
            checks++; if (seg_ram !== m_ram_vec()) begin errors++; $display("FAIL rand_seg_ram it%0d: got %h want %h", it, seg_ram, m_ram_vec()); end
            checks++; if (got_fw !== int'(exp_fw)) begin errors++; $display("FAIL rand_frame_wr it%0d: got %0d want %0d", it, got_fw, exp_fw); end
        end
    endtask

    task automatic test_reset_mid_write();
        int got_fw, fw0;
        bit exp_fw;
        tx[0] = 8'h44;
        run_frame(1, 0, 8'h00, got_fw, exp_fw);
        tx[0] = 8'h8A;
        run_frame(1, 0, 8'h00, got_fw, exp_fw);
        fw0 = frame_wr_cnt;
        start_frame();
        send_bits(8'hC0, 8);
        send_bits(8'h11, 8);
        send_bits(8'h22, 4);
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (seg_ram !== 128'h0) begin errors++; $display("FAIL midrst_seg_ram: got %h want 0", seg_ram); end
        checks++; if (disp_on !== 1'b0) begin errors++; $display("FAIL midrst_disp_on: got %b want 0", disp_on); end
        checks++; if (bright !== 3'd0) begin errors++; $display("FAIL midrst_bright: got %0d want 0", bright); end
        checks++; if (dio_oe !== 1'b0 || dio_out !== 1'b0) begin errors++; $display("FAIL midrst_dio: got oe=%b out=%b want 0 0", dio_oe, dio_out); end
        reset_n = 1'b1;
        model_reset();
        send_bits(8'h02, 4);
        send_bits(8'h33, 8);
        end_frame();
        checks++; if (frame_wr_cnt - fw0 !== 0) begin errors++; $display("FAIL midrst_frame_wr: got %0d want 0", frame_wr_cnt - fw0); end
        checks++; if (seg_ram !== 128'h0) begin errors++; $display("FAIL midrst_idle_seg_ram: got %h want 0", seg_ram); end
        tx[0] = 8'hC2;
        tx[1] = 8'h33;
        tx[2] = 8'h44;
        tx[3] = 8'h55;
        run_frame(4, 0, 8'h00, got_fw, exp_fw);
        checks++; if (seg_ram !== m_ram_vec()) begin errors++; $display("FAIL postrst_seg_ram: got %h want %h", seg_ram, m_ram_vec()); end
        checks++; if (got_fw !== 1) begin errors++; $display("FAIL postrst_frame_wr: got %0d want 1", got_fw); end
    endtask

    initial begin
        test_reset();
        test_display();
        test_auto_write();
        test_fixed_write();
        test_key_read();
        test_abort();
        test_random_writes();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
